// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : y86_pkg
//  Purpose  : Shared constants for the Y86 pipeline: instruction codes,
//             status codes, the "no register" id and the run-FSM state type.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Status codes
    localparam logic [3:0] STAT_AOK = 4'h1;
    localparam logic [3:0] STAT_HLT = 4'h2;
    localparam logic [3:0] STAT_ADR = 4'h3;
    localparam logic [3:0] STAT_INS = 4'h4;

    // Register id meaning "no register"
    localparam logic [3:0] REG_NONE = 4'hF;

    // Run-control FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } run_state_t;

endpackage : y86_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_perf_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : perf_ctr
//  Purpose  : Saturating up-counter with enable. Sticks at all-ones instead
//             of wrapping so a long run never reports a small count.
//  Ports    : clk   in  1      clock
//             rst   in  1      asynchronous active-high reset (clears count)
//             en    in  1      advance by one this cycle
//             count out CNT_W  current count
//  Revision : 1.0  initial release
// ============================================================================
module perf_ctr #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != C_MAX)) begin
            count <= count + C_ONE;
        end
    end

endmodule : perf_ctr
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Purpose  : Pipeline control for the 5-stage Y86 core. Generates stall and
//             bubble strobes for the F/D/E/M/W registers (load/use interlock,
//             ret hazard, jXX mispredict), gates set_cc, runs the
//             IDLE/RUN/DRAIN/HALT run FSM and keeps performance counters.
//  Ports    : clk, rst                     clock, async active-high reset
//             go                           start pulse (IDLE only)
//             D/E/M/W_icode                stage icodes
//             E_dstM, d_srcA, d_srcB       load/use operands
//             e_cnd                        execute branch condition
//             m_stat, W_stat               memory / writeback status
//             F_stall, D_stall, D_bubble,
//             E_bubble, M_bubble, W_stall  stage-register strobes
//             set_cc                       execute may update CCs
//             running, halted, final_stat  run state
//             cyc_cnt, ret_cnt, lu_cnt,
//             mp_cnt                       saturating perf counters
//  Revision : 1.0  initial release
// ============================================================================
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int         CNT_W = 32,
    parameter logic [3:0] RNONE = REG_NONE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       W_icode,
    input  logic [3:0]       E_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic             e_cnd,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic             running,
    output logic             halted,
    output logic [3:0]       final_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt
);

    run_state_t r_state;

    logic w_lu;
    logic w_ret;
    logic w_mp;
    logic w_m_bad;
    logic w_w_bad;
    logic w_active;

    // Hazard detection, evaluated in the same cycle as the stage inputs.
    assign w_lu    = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                     (E_dstM != RNONE) &&
                     ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign w_ret   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign w_mp    = (E_icode == I_JXX) && !e_cnd;
    assign w_m_bad = (m_stat != STAT_AOK);
    assign w_w_bad = (W_stat != STAT_AOK);
    assign w_active = (r_state == ST_RUN) || (r_state == ST_DRAIN);

    // Strobe generation. When lu and ret coincide, D is held rather than
    // bubbled so the load's consumer is not lost.
    always_comb begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b1;
        set_cc   = 1'b0;
        case (r_state)
            ST_RUN, ST_DRAIN: begin
                // DRAIN blocks all new fetches while older work completes.
                F_stall  = w_lu || w_ret || (r_state == ST_DRAIN);
                D_stall  = w_lu;
                D_bubble = w_mp || (w_ret && !w_lu);
                E_bubble = w_mp || w_lu;
                M_bubble = w_m_bad || w_w_bad;
                W_stall  = w_w_bad;
                set_cc   = (E_icode == I_OPQ) && !w_m_bad && !w_w_bad;
            end
            ST_HALT: begin
                D_bubble = 1'b0;
                E_bubble = 1'b0;
                M_bubble = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Run FSM with registered status outputs. A bad W status wins over a bad
    // M status because the faulting instruction has already reached W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            running    <= 1'b0;
            halted     <= 1'b0;
            final_stat <= STAT_AOK;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (go) begin
                        r_state <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if (w_w_bad) begin
                        r_state    <= ST_HALT;
                        running    <= 1'b0;
                        halted     <= 1'b1;
                        final_stat <= W_stat;
                    end else if (w_m_bad) begin
                        r_state <= ST_DRAIN;
                    end
                end
                default: begin
                    // HALT is frozen until reset.
                end
            endcase
        end
    end

    perf_ctr #(.CNT_W(CNT_W)) u_cyc_ctr (
        .clk   (clk),
        .rst   (rst),
        .en    (w_active),
        .count (cyc_cnt)
    );

    // Bubbles travel as NOPs, so a NOP in W is never counted as retired.
    perf_ctr #(.CNT_W(CNT_W)) u_ret_ctr (
        .clk   (clk),
        .rst   (rst),
        .en    (w_active && !w_w_bad && (W_icode != I_NOP)),
        .count (ret_cnt)
    );

    perf_ctr #(.CNT_W(CNT_W)) u_lu_ctr (
        .clk   (clk),
        .rst   (rst),
        .en    (w_active && w_lu),
        .count (lu_cnt)
    );

    perf_ctr #(.CNT_W(CNT_W)) u_mp_ctr (
        .clk   (clk),
        .rst   (rst),
        .en    (w_active && w_mp),
        .count (mp_cnt)
    );

endmodule : pipe_ctrl
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl
//  Purpose  : Directed self-checking bench for pipe_ctrl. A second instance
//             with 3-bit counters exercises counter saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;
    import y86_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       go;
    logic [3:0] D_icode, E_icode, M_icode, W_icode;
    logic [3:0] E_dstM, d_srcA, d_srcB;
    logic       e_cnd;
    logic [3:0] m_stat, W_stat;

    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
    logic        running, halted;
    logic [3:0]  final_stat;
    logic [31:0] cyc_cnt, ret_cnt, lu_cnt, mp_cnt;

    logic        s_F_stall, s_D_stall, s_D_bubble, s_E_bubble, s_M_bubble, s_W_stall, s_set_cc;
    logic        s_running, s_halted;
    logic [3:0]  s_final_stat;
    logic [2:0]  s_cyc_cnt, s_ret_cnt, s_lu_cnt, s_mp_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .go(go),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .W_icode(W_icode),
        .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB), .e_cnd(e_cnd),
        .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc),
        .running(running), .halted(halted), .final_stat(final_stat),
        .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt)
    );

    pipe_ctrl #(.CNT_W(3)) u_dut_small (
        .clk(clk), .rst(rst), .go(go),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .W_icode(W_icode),
        .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB), .e_cnd(e_cnd),
        .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(s_F_stall), .D_stall(s_D_stall), .D_bubble(s_D_bubble), .E_bubble(s_E_bubble),
        .M_bubble(s_M_bubble), .W_stall(s_W_stall), .set_cc(s_set_cc),
        .running(s_running), .halted(s_halted), .final_stat(s_final_stat),
        .cyc_cnt(s_cyc_cnt), .ret_cnt(s_ret_cnt), .lu_cnt(s_lu_cnt), .mp_cnt(s_mp_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        D_icode = I_NOP; E_icode = I_NOP; M_icode = I_NOP; W_icode = I_NOP;
        E_dstM  = REG_NONE; d_srcA = REG_NONE; d_srcB = REG_NONE;
        e_cnd   = 1'b0;
        m_stat  = STAT_AOK; W_stat = STAT_AOK;
    endtask

    initial begin
        rst = 1'b1;
        go  = 1'b0;
        quiet();
        tick();
        tick();
        rst = 1'b0;
        #1;
        // Reset / IDLE
        chk("rst_running",  {31'd0, running},    32'd0);
        chk("rst_halted",   {31'd0, halted},     32'd0);
        chk("rst_final",    {28'd0, final_stat}, 32'd1);
        chk("idle_fstall",  {31'd0, F_stall},    32'd1);
        chk("idle_dbubble", {31'd0, D_bubble},   32'd1);
        chk("idle_mbubble", {31'd0, M_bubble},   32'd1);
        chk("idle_wstall",  {31'd0, W_stall},    32'd1);
        chk("idle_setcc",   {31'd0, set_cc},     32'd0);
        chk("rst_cyc",      cyc_cnt,             32'd0);

        // Start
        go = 1'b1;
        tick();
        go = 1'b0;
        #1;
        chk("go_running",   {31'd0, running},  32'd1);
        chk("go_cyc",       cyc_cnt,           32'd0);
        chk("go_ret",       ret_cnt,           32'd0);
        chk("run_dbubble",  {31'd0, D_bubble}, 32'd0);
        chk("run_fstall",   {31'd0, F_stall},  32'd0);
        chk("run_ebubble",  {31'd0, E_bubble}, 32'd0);
        chk("run_mbubble",  {31'd0, M_bubble}, 32'd0);
        chk("run_wstall",   {31'd0, W_stall},  32'd0);

        // Load/use interlock
        E_icode = I_MRMOVQ; E_dstM = 4'd3; d_srcB = 4'd3;
        #1;
        chk("lu_fstall",  {31'd0, F_stall},  32'd1);
        chk("lu_dstall",  {31'd0, D_stall},  32'd1);
        chk("lu_ebubble", {31'd0, E_bubble}, 32'd1);
        chk("lu_dbubble", {31'd0, D_bubble}, 32'd0);
        tick();
        chk("lu_cnt1", lu_cnt,  32'd1);
        chk("lu_cyc1", cyc_cnt, 32'd1);

        // Retire OPQs; set_cc allowed with clean status
        quiet();
        E_icode = I_OPQ; W_icode = I_OPQ;
        #1;
        chk("opq_setcc", {31'd0, set_cc}, 32'd1);
        repeat (9) tick();
        chk("ret_cnt9",      ret_cnt,             32'd9);
        chk("cyc_cnt10",     cyc_cnt,             32'd10);
        chk("sat_ret",       {29'd0, s_ret_cnt},  32'd7);
        chk("sat_cyc",       {29'd0, s_cyc_cnt},  32'd7);
        chk("small_lu",      {29'd0, s_lu_cnt},   32'd1);

        // ret moving through D, E, M
        quiet();
        D_icode = I_RET;
        #1;
        chk("retD_fstall",  {31'd0, F_stall},  32'd1);
        chk("retD_dbubble", {31'd0, D_bubble}, 32'd1);
        chk("retD_dstall",  {31'd0, D_stall},  32'd0);
        tick();
        D_icode = I_NOP; E_icode = I_RET;
        #1;
        chk("retE_fstall",  {31'd0, F_stall},  32'd1);
        chk("retE_dbubble", {31'd0, D_bubble}, 32'd1);
        tick();
        E_icode = I_NOP; M_icode = I_RET;
        #1;
        chk("retM_fstall",  {31'd0, F_stall},  32'd1);
        chk("retM_dbubble", {31'd0, D_bubble}, 32'd1);
        tick();
        // ret and lu together: D held, not bubbled
        E_icode = I_MRMOVQ; E_dstM = 4'd3; d_srcA = 4'd3;
        #1;
        chk("retlu_dstall",  {31'd0, D_stall},  32'd1);
        chk("retlu_dbubble", {31'd0, D_bubble}, 32'd0);
        chk("retlu_fstall",  {31'd0, F_stall},  32'd1);
        tick();
        chk("lu_cnt2",  lu_cnt,  32'd2);
        chk("cyc_cnt14", cyc_cnt, 32'd14);

        // Mispredict
        quiet();
        E_icode = I_JXX; e_cnd = 1'b0;
        #1;
        chk("mp_dbubble", {31'd0, D_bubble}, 32'd1);
        chk("mp_ebubble", {31'd0, E_bubble}, 32'd1);
        tick();
        chk("mp_cnt1", mp_cnt, 32'd1);
        e_cnd = 1'b1;
        #1;
        chk("tk_dbubble", {31'd0, D_bubble}, 32'd0);
        chk("tk_ebubble", {31'd0, E_bubble}, 32'd0);
        tick();
        chk("mp_cnt_hold", mp_cnt, 32'd1);

        // Memory fault -> DRAIN
        quiet();
        E_icode = I_OPQ; m_stat = STAT_ADR;
        #1;
        chk("mbad_setcc",   {31'd0, set_cc},   32'd0);
        chk("mbad_mbubble", {31'd0, M_bubble}, 32'd1);
        chk("mbad_wstall",  {31'd0, W_stall},  32'd0);
        tick();
        go = 1'b1;
        #1;
        chk("drain_running", {31'd0, running}, 32'd1);
        chk("drain_halted",  {31'd0, halted},  32'd0);
        chk("drain_fstall",  {31'd0, F_stall}, 32'd1);
        chk("drain_cyc",     cyc_cnt,          32'd17);

        // Fault reaches W -> HALT
        W_stat = STAT_ADR;
        #1;
        chk("wbad_wstall",  {31'd0, W_stall},  32'd1);
        chk("wbad_mbubble", {31'd0, M_bubble}, 32'd1);
        tick();
        chk("halt_halted",  {31'd0, halted},     32'd1);
        chk("halt_running", {31'd0, running},    32'd0);
        chk("halt_final",   {28'd0, final_stat}, 32'd3);
        chk("halt_fstall",  {31'd0, F_stall},    32'd1);
        chk("halt_dstall",  {31'd0, D_stall},    32'd1);
        chk("halt_dbubble", {31'd0, D_bubble},   32'd0);
        chk("halt_mbubble", {31'd0, M_bubble},   32'd0);
        chk("halt_setcc",   {31'd0, set_cc},     32'd0);
        chk("halt_cyc",     cyc_cnt,             32'd18);
        W_stat = STAT_HLT;
        tick();
        tick();
        go = 1'b0;
        chk("frozen_cyc",   cyc_cnt,             32'd18);
        chk("frozen_final", {28'd0, final_stat}, 32'd3);
        chk("frozen_halt",  {31'd0, halted},     32'd1);

        // Asynchronous reset in the middle of DRAIN
        quiet();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        go  = 1'b1;
        tick();
        go  = 1'b0;
        m_stat = STAT_ADR;
        tick();
        tick();
        chk("d2_cyc",     cyc_cnt,          32'd2);
        chk("d2_running", {31'd0, running}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cyc",     cyc_cnt,             32'd0);
        chk("arst_running", {31'd0, running},    32'd0);
        chk("arst_final",   {28'd0, final_stat}, 32'd1);
        chk("arst_fstall",  {31'd0, F_stall},    32'd1);
        chk("arst_dbubble", {31'd0, D_bubble},   32'd1);
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pipe_ctrl
`default_nettype wire
